// File: rtl/ds1302_pkg.sv
// rtl/ds1302_pkg.sv - DS1302 command bytes, FSM states and write-frame builder
package ds1302_pkg;

    localparam logic [7:0] CMD_WP_W    = 8'h8E;
    localparam logic [7:0] CMD_BURST_W = 8'hBE;
    localparam logic [7:0] CMD_BURST_R = 8'hBF;
    localparam logic [7:0] WP_ON       = 8'h80;

    typedef enum logic [2:0] {
        S_GAP,
        S_IDLE,
        S_ISSUE_WR,
        S_ISSUE_RD,
        S_WAIT
    } state_t;

    // Frame bytes from LSB: WP cmd, WP off, burst-write cmd, sec..yr, WP on.
    // The CH bit (sec bit7) is cleared so the oscillator keeps running.
    function automatic logic [87:0] build_wr_frame(input logic [55:0] t);
        return {WP_ON, t[55:8], 1'b0, t[6:0], CMD_BURST_W, 8'h00, CMD_WP_W};
    endfunction

endpackage

// File: rtl/ds1302_if.sv
// rtl/ds1302_if.sv - user request and serial-interface signals of the DS1302 sequencer
interface ds1302_if;

    logic        set_req;
    logic [55:0] set_time;
    logic        set_ack;
    logic [55:0] time_out;
    logic        time_vld;
    logic        busy;
    logic        err_tmo;
    logic        wr_vld;
    logic        wr;
    logic [87:0] din;
    logic [55:0] data;
    logic        opera_done;

    modport master (
        input  set_req, set_time, data, opera_done,
        output set_ack, time_out, time_vld, busy, err_tmo, wr_vld, wr, din
    );

    modport slave (
        output set_req, set_time, data, opera_done,
        input  set_ack, time_out, time_vld, busy, err_tmo, wr_vld, wr, din
    );

endinterface

// File: rtl/ds1302_tick.sv
// rtl/ds1302_tick.sv - period counter that raises a pending flag on every wrap
module ds1302_tick #(
    parameter int PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic clr_pend,
    output logic pend
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = !restart && (cnt == W'(PERIOD - 1));

    // count up, restart on request or wrap; a wrap sets pend and wins over a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            if (restart || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            pend <= (pend && !clr_pend) || wrap;
        end
    end

endmodule

// File: rtl/ds1302_ctrl.sv
// rtl/ds1302_ctrl.sv - DS1302 sequencer: power-on load, periodic burst read, user set-time
module ds1302_ctrl
    import ds1302_pkg::*;
#(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          POLL_CYC  = CLK_HZ / 2,
    parameter int          GAP_CYC   = CLK_HZ / 200_000,
    parameter int          TMO_CYC   = CLK_HZ / 25,
    parameter logic [55:0] INIT_TIME = 56'h24_06_01_01_00_00_00,
    parameter bit          INIT_EN   = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    ds1302_if.master bus
);

    state_t state, next_state;

    logic        init_done;
    logic        use_init;
    logic        set_ack_c;
    logic        wr_vld_q, wr_q, busy_q, err_q, time_vld_q;
    logic [87:0] din_q;
    logic [55:0] time_q;
    logic        poll_pend, gap_pend, tmo_pend;
    logic        poll_clr, gap_restart, tmo_restart;

    assign poll_clr    = (state == S_IDLE) && (next_state == S_ISSUE_RD);
    assign gap_restart = (state != S_GAP);
    assign tmo_restart = (state != S_WAIT) || bus.opera_done;

    ds1302_tick #(.PERIOD(POLL_CYC)) u_poll (
        .clk(clk), .rst(rst), .restart(1'b0), .clr_pend(poll_clr), .pend(poll_pend)
    );

    ds1302_tick #(.PERIOD(GAP_CYC)) u_gap (
        .clk(clk), .rst(rst), .restart(gap_restart), .clr_pend(gap_restart), .pend(gap_pend)
    );

    ds1302_tick #(.PERIOD(TMO_CYC)) u_tmo (
        .clk(clk), .rst(rst), .restart(tmo_restart), .clr_pend(tmo_restart), .pend(tmo_pend)
    );

    // state register; reset lands in the gap so CE recovery applies after reset too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_GAP;
        end else begin
            state <= next_state;
        end
    end

    // next state with idle priority: power-on load, then user set, then poll
    always_comb begin
        next_state = state;
        use_init   = 1'b0;
        set_ack_c  = 1'b0;
        case (state)
            S_GAP: begin
                if (gap_pend) next_state = S_IDLE;
            end
            S_IDLE: begin
                if (INIT_EN && !init_done) begin
                    next_state = S_ISSUE_WR;
                    use_init   = 1'b1;
                end else if (bus.set_req) begin
                    next_state = S_ISSUE_WR;
                    set_ack_c  = 1'b1;
                end else if (poll_pend) begin
                    next_state = S_ISSUE_RD;
                end
            end
            S_ISSUE_WR, S_ISSUE_RD: next_state = S_WAIT;
            S_WAIT: begin
                if (bus.opera_done || tmo_pend) next_state = S_GAP;
            end
            default: next_state = S_GAP;
        endcase
    end

    // frame/direction load on leaving idle, start pulse one cycle later, read-back capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_done  <= 1'b0;
            wr_vld_q   <= 1'b0;
            wr_q       <= 1'b1;
            din_q      <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            time_q     <= '0;
            time_vld_q <= 1'b0;
        end else begin
            wr_vld_q   <= (state == S_ISSUE_WR) || (state == S_ISSUE_RD);
            busy_q     <= (next_state == S_WAIT);
            time_vld_q <= 1'b0;
            if (state == S_IDLE && next_state == S_ISSUE_WR) begin
                wr_q  <= 1'b0;
                din_q <= build_wr_frame(use_init ? INIT_TIME : bus.set_time);
                if (use_init) init_done <= 1'b1;
            end
            if (state == S_IDLE && next_state == S_ISSUE_RD) begin
                wr_q  <= 1'b1;
                din_q <= {80'd0, CMD_BURST_R};
            end
            if (state == S_WAIT && bus.opera_done && wr_q) begin
                time_q     <= bus.data;
                time_vld_q <= 1'b1;
            end
            if (state == S_WAIT && !bus.opera_done && tmo_pend) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.set_ack  = set_ack_c;
    assign bus.wr_vld   = wr_vld_q;
    assign bus.wr       = wr_q;
    assign bus.din      = din_q;
    assign bus.busy     = busy_q;
    assign bus.err_tmo  = err_q;
    assign bus.time_out = time_q;
    assign bus.time_vld = time_vld_q;

endmodule
